redundant_normalizer: RTL and testbench

- Sits directly downstream of the post-adder stage.
- Accepts one redundant limb-vector result, where each limb is a value plus a carry extension.
- Resolves all carries into a canonical binary integer, then reduces it into [0, p) by bounded repeated subtraction of the field modulus.
- Delivers a fully reduced Fp element over a valid/ready handshake to the writeback/output path.

---
 rtl/redundant_normalizer.sv | 152 +++++++++++++++
 tb/tb_redundant_normalizer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/redundant_normalizer.sv
// Carry-resolving normalizer: folds a redundant limb vector into a canonical Fp element.
// Build option NORM_CARRY_LOOKAHEAD_EN resolves all limbs in one cycle instead of limb-serially.
module redundant_normalizer #(
    parameter int ADD_DIV = 4,
    parameter int LIMB_W = 64,
    parameter int CARRY_W = 8,
    parameter logic [ADD_DIV*LIMB_W-1:0] MOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int MAX_SUB = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADD_DIV*(CARRY_W+LIMB_W)-1:0]   din,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADD_DIV*LIMB_W-1:0]             dout,
    output logic                                  err
);
    localparam int EW = CARRY_W + LIMB_W;
    localparam int DW = ADD_DIV * LIMB_W;
    localparam int AW = DW + CARRY_W + 1;
    localparam int SW = $clog2(MAX_SUB + 1);

    typedef enum logic [1:0] {IDLE, PROP, RED, DONE} state_t;

    state_t              state;
    state_t              next;
    logic [ADD_DIV*EW-1:0] din_r;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       mod_ext;
    logic [SW-1:0]       cnt;
    logic                err_p;
    logic                accept;
    logic                ge;
    logic                sub_full;

    assign mod_ext  = AW'(MOD);
    assign accept   = in_valid && in_ready;
    assign ge       = acc >= mod_ext;
    assign sub_full = cnt == SW'(MAX_SUB);

`ifdef NORM_CARRY_LOOKAHEAD_EN
    function automatic logic [AW-1:0] resolve(input logic [ADD_DIV*EW-1:0] d);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < ADD_DIV; i++)
            s = s + (AW'(d[i*EW +: EW]) << (i * LIMB_W));
        return s;
    endfunction
`else
    localparam int IW = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;

    logic [CARRY_W:0]  c;
    logic [CARRY_W:0]  c_next;
    logic [IW-1:0]     idx;
    logic [EW-1:0]     limb;
    logic [LIMB_W:0]   t;
    logic              last;

    // c never exceeds 2^CARRY_W, so the extra bit is enough headroom
    assign limb   = din_r[idx*EW +: EW];
    assign t      = {1'b0, limb[LIMB_W-1:0]} + (LIMB_W+1)'(c);
    assign c_next = {1'b0, limb[EW-1:LIMB_W]} + (CARRY_W+1)'(t[LIMB_W]);
    assign last   = idx == IW'(ADD_DIV - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next;
            in_ready <= next == IDLE;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (accept) next = PROP;
`ifdef NORM_CARRY_LOOKAHEAD_EN
            PROP: next = RED;
`else
            PROP: if (last) next = RED;
`endif
            RED:  if (!ge || sub_full) next = DONE;
            DONE: if (out_valid && out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_r     <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_p     <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            err       <= 1'b0;
`ifndef NORM_CARRY_LOOKAHEAD_EN
            c         <= '0;
            idx       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        din_r <= din;
                        cnt   <= '0;
`ifndef NORM_CARRY_LOOKAHEAD_EN
                        c     <= '0;
                        idx   <= '0;
`endif
                    end
                end
                PROP: begin
`ifdef NORM_CARRY_LOOKAHEAD_EN
                    acc <= resolve(din_r);
`else
                    acc[idx*LIMB_W +: LIMB_W] <= t[LIMB_W-1:0];
                    c   <= c_next;
                    idx <= idx + IW'(1);
                    if (last)
                        acc[AW-1 -: CARRY_W+1] <= c_next;
`endif
                end
                RED: begin
                    if (ge && !sub_full) begin
                        acc <= acc - mod_ext;
                        cnt <= cnt + SW'(1);
                    end else begin
                        err_p <= ge;
                    end
                end
                DONE: begin
                    // publish one cycle after entry so dout/err/out_valid move together
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        dout      <= acc[DW-1:0];
                        err       <= err_p;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_redundant_normalizer.sv
// Randomized bench for redundant_normalizer against an arithmetic reference model.
// Honours NORM_CARRY_LOOKAHEAD_EN for the expected latency.
module tb_redundant_normalizer;
    localparam int DIN_W = 4 * 72;
    localparam logic [255:0] MOD =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
`ifdef NORM_CARRY_LOOKAHEAD_EN
    localparam int BASE = 3;
`else
    localparam int BASE = 6;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DIN_W-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [255:0]     dout;
    logic             err;

    int checks = 0;
    int failures = 0;

    redundant_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Value is the plain weighted sum of {carry,val} limbs, then up to 4 subtractions
    function automatic void model(input logic [DIN_W-1:0] d, output logic [255:0] r,
                                  output logic e, output int lat);
        logic [319:0] v;
        logic [71:0]  f;
        int k;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            f = d[i*72 +: 72];
            v = v + (320'(f) << (64 * i));
        end
        k = 0;
        while (v >= 320'(MOD) && k < 4) begin
            v = v - 320'(MOD);
            k++;
        end
        e = v >= 320'(MOD);
        r = v[255:0];
        lat = BASE + k;
    endfunction

    function automatic logic [DIN_W-1:0] put(input logic [DIN_W-1:0] d, input int i,
                                             input logic [7:0] c, input logic [63:0] v);
        d[i*72 +: 72] = {c, v};
        return d;
    endfunction

    function automatic logic [DIN_W-1:0] rnd_din();
        logic [DIN_W-1:0] d;
        for (int i = 0; i < 9; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send(input logic [DIN_W-1:0] d, input int hold);
        logic [255:0] ed;
        logic         ee;
        int           el;
        int           n;
        int           lat;
        model(d, ed, ee, el);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        din = d;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        din = rnd_din();
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, el);
        check("dout", dout, ed);
        check("err", err, ee);
        check("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            din = rnd_din();
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_dout", dout, ed);
            check("hold_err", err, ee);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DIN_W-1:0] d;
        logic [255:0]     m;
        logic [257:0]     m3;
        int               seen;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send('0, 0);

        d = '0;
        d = put(d, 0, 8'h01, 64'h0);
        d = put(d, 1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        send(d, 0);

        m = MOD;
        d = '0;
        for (int i = 0; i < 4; i++) d = put(d, i, 8'h00, m[i*64 +: 64]);
        d = put(d, 0, 8'h00, m[63:0] + 64'd5);
        send(d, 0);

        m3 = 258'(MOD) * 258'd3 + 258'd1;
        d = '0;
        for (int i = 0; i < 4; i++) d = put(d, i, 8'h00, m3[i*64 +: 64]);
        d = put(d, 3, {6'd0, m3[257:256]}, m3[255:192]);
        send(d, 0);

        d = '0;
        for (int i = 0; i < 4; i++) d = put(d, i, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        send(d, 0);

        d = put('0, 2, 8'h00, 64'h1234);
        send(d, 10);

        for (int n = 0; n < 24; n++) begin
            d = rnd_din();
            for (int i = 0; i < 4; i++) begin
                logic [7:0] cy;
                cy = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
                d[i*72+64 +: 8] = cy;
            end
            if (n % 4 == 0) d[255:248] = 8'h00;
            send(d, $urandom_range(0, 3));
        end

        d = '0;
        m = MOD;
        for (int i = 0; i < 4; i++) d = put(d, i, 8'h00, m[i*64 +: 64]);
        d = put(d, 0, 8'h00, m[63:0] + 64'd9);
        send(d, 0);

        din = rnd_din();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_dout", dout, 0);
        check("abort_err", err, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        check("abort_in_ready_back", in_ready, 1);
        out_ready = 1'b0;

        send(put('0, 1, 8'h02, 64'h5), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
